// File: rtl/prop_mon_pkg.sv
// Shared types for the "always p disable iff (b)" run-time monitor.
// Holds the FSM state, the verdict encoding and the default failure-record shape.
package prop_mon_pkg;

   localparam int unsigned DEF_CNT_W     = 16;
   localparam int unsigned DEF_LOG_DEPTH = 4;

   typedef enum logic {
      IDLE,
      ARMED
   } state_t;

   typedef enum logic [1:0] {
      V_NONE,
      V_PASS,
      V_FAIL,
      V_DIS
   } verdict_t;

   typedef struct packed {
      logic [DEF_CNT_W-1:0] offset;
   } fail_rec_t;

endpackage

// File: rtl/fail_log_fifo.sv
// Synchronous FIFO holding failure offsets, with a sticky overflow flag.
// A push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module fail_log_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic         ovf_q, ovf_d;
   logic         full;
   logic         do_push;
   logic         do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      wr_d    = wr_q;
      rd_d    = rd_q;
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      ovf_d   = ovf_q || (push && !do_push);
      if (do_push) begin
         wr_d = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ovf_q <= ovf_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= din;
      end
   end

   assign dout     = empty ? '0 : mem_q[rd_q[AW-1:0]];
   assign overflow = ovf_q;

endmodule

// File: rtl/prop_always_mon.sv
// Evaluates "always p" with a "disable iff (b)" abort, one attempt at a time,
// and logs the sample index of each failure into a small FIFO.
module prop_always_mon
   import prop_mon_pkg::*;
#(
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned LOG_DEPTH = DEF_LOG_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             p,
   input  logic             b,
   input  logic             stop,
   output logic             active,
   output logic             passed,
   output logic             failed,
   output logic             disabled,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             fail_vld,
   output logic [CNT_W-1:0] fail_cycle,
   input  logic             fail_rdy,
   output logic             log_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   verdict_t         verdict_q, verdict_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] idx;
   logic             push;
   logic             log_empty;

   // idx is the sample index of the current cycle: 0 on an accepted start.
   always_comb begin
      state_d   = state_q;
      verdict_d = V_NONE;
      cnt_d     = cnt_q;
      push      = 1'b0;
      idx       = (state_q == IDLE) ? '0 : cnt_q;
      if (state_q == ARMED || start) begin
         state_d = IDLE;
         cnt_d   = idx;
         if (b) begin
            verdict_d = V_DIS;
         end else if (!p) begin
            verdict_d = V_FAIL;
            push      = 1'b1;
         end else if (stop) begin
            verdict_d = V_PASS;
         end else begin
            state_d = ARMED;
            if (idx != CNT_MAX) begin
               cnt_d = idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         verdict_q <= V_NONE;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         verdict_q <= verdict_d;
         cnt_q     <= cnt_d;
      end
   end

   assign active    = (state_q == ARMED);
   assign passed    = (verdict_q == V_PASS);
   assign failed    = (verdict_q == V_FAIL);
   assign disabled  = (verdict_q == V_DIS);
   assign cycle_cnt = cnt_q;
   assign fail_vld  = !log_empty;

   fail_log_fifo #(
      .W     (CNT_W),
      .DEPTH (LOG_DEPTH)
   ) u_fail_log (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .din      (idx),
      .pop      (fail_rdy),
      .dout     (fail_cycle),
      .empty    (log_empty),
      .overflow (log_ovf)
   );

endmodule
